// File: rtl/uart_rx_read_arbiter.sv
// Arbitrates the UART RX FIFO read port among NUM_REQ requesters; returns byte + error flags to the winner.
// Optional round-robin arbitration under `define UART_RX_ARB_RR_EN (default: fixed priority, lowest index wins).
module uart_rx_read_arbiter #(
  parameter int DATA_SIZE  = 8,
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   rvalid_o,
  output logic [DATA_SIZE-1:0] rdata_o,
  output logic [3:0]           rerr_o,
  output logic [2:0]           gnt_idx_o,
  output logic                 busy_o,
  output logic                 rx_read_o,
  input  logic [DATA_SIZE-1:0] rx_data_i,
  input  logic [7:0]           rx_status_i
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] wait_cnt;
  logic       grant;
  logic [2:0] winner;
  logic       unused_status;

  // Only empty and the captured error flags matter here.
  assign unused_status = ^{rx_status_i[7], rx_status_i[1:0]};

  assign grant = (state == IDLE) && (|req_i) && !rx_status_i[2];

`ifdef UART_RX_ARB_RR_EN
  logic [2:0]         rr_ptr;
  logic [NUM_REQ-1:0] upper_req;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
  always_comb begin
    upper_req = '0;
    winner    = '0;
    for (int j = 0; j < NUM_REQ; j++)
      upper_req[j] = req_i[j] && (j >= int'(rr_ptr));
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req_i[j]) winner = 3'(j);
    if (|upper_req) begin
      for (int j = NUM_REQ - 1; j >= 0; j--)
        if (upper_req[j]) winner = 3'(j);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
  end
`else
  always_comb begin
    winner = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req_i[j]) winner = 3'(j);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      gnt_idx_o <= '0;
      rdata_o   <= '0;
      rerr_o    <= '0;
    end else begin
      if (grant)
        gnt_idx_o <= winner;
      if (state == READ)
        wait_cnt <= 2'(RD_LATENCY - 1);
      else if (state == WAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
      // Last WAIT cycle is exactly RD_LATENCY cycles after the strobe.
      if (state == WAIT && wait_cnt == 2'd0) begin
        rdata_o <= rx_data_i;
        rerr_o  <= rx_status_i[6:3];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int j = 0; j < NUM_REQ; j++)
      rvalid_o[j] = (state == RESP) && (gnt_idx_o == 3'(j));
    busy_o    = (state != IDLE);
    rx_read_o = (state == READ);
  end

endmodule
